// File: rtl/seq_chk_pkg.sv
// Shared types and limits for the delayed-implication checker.
// Provides the comparison mode enum and channel/delay bounds.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    CMP_GT,
    CMP_GE,
    CMP_EQ,
    CMP_NE
  } cmp_mode_e;

  localparam int unsigned MAX_NCH   = 16;
  localparam int unsigned MAX_DELAY = 15;

endpackage

// File: rtl/seq_chk_lane.sv
// One checker channel: obligation shift register, comparator, counter.
// Ports: clk, rst_n, en, clr, trig, a, b -> fail_now, fail, pending, cnt.
module seq_chk_lane
  import seq_chk_pkg::*;
#(
  parameter int        W     = 32,
  parameter int        DELAY = 1,
  parameter cmp_mode_e MODE  = CMP_GT,
  parameter int        CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          trig,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          fail_now,
  output logic          fail,
  output logic          pending,
  output logic [CW-1:0] cnt
);

  logic [DELAY-1:0] sr;
  logic [DELAY-1:0] sr_nx;
  logic             ok;
  logic             check;

  if (DELAY == 1) begin : g_d1
    assign sr_nx = trig;
  end else begin : g_dn
    assign sr_nx = {sr[DELAY-2:0], trig};
  end

  always_comb begin
    ok = 1'b0;
    unique case (MODE)
      CMP_GT: ok = (a > b);
      CMP_GE: ok = (a >= b);
      CMP_EQ: ok = (a == b);
      CMP_NE: ok = (a != b);
      default: ok = 1'b0;
    endcase
  end

  // Only an obligation actually leaving the last stage is evaluated.
  assign check    = en & sr[DELAY-1];
  assign fail_now = check & ~ok & ~clr;
  assign pending  = |sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      fail <= 1'b0;
      cnt  <= '0;
    end else if (clr) begin
      sr   <= '0;
      fail <= 1'b0;
      cnt  <= '0;
    end else begin
      if (en) sr <= sr_nx;
      fail <= fail_now;
      if (fail_now && (cnt != '1))
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_delay_checker.sv
// Multi-channel ##DELAY implication checker with first-failure capture.
// Ports: clk, rst_n, en, clr, trig, a, b -> fail, fail_any, pending,
// fail_cnt, first_fail_vld, first_fail_time, first_fail_ch.
module seq_delay_checker
  import seq_chk_pkg::*;
#(
  parameter int        NCH   = 4,
  parameter int        W     = 32,
  parameter int        DELAY = 1,
  parameter cmp_mode_e MODE  = CMP_GT,
  parameter int        CW    = 8,
  parameter int        TW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NCH-1:0]    trig,
  input  logic [NCH*W-1:0]  a,
  input  logic [NCH*W-1:0]  b,
  output logic [NCH-1:0]    fail,
  output logic              fail_any,
  output logic [NCH-1:0]    pending,
  output logic [NCH*CW-1:0] fail_cnt,
  output logic              first_fail_vld,
  output logic [TW-1:0]     first_fail_time,
  output logic [3:0]        first_fail_ch
);

  logic [NCH-1:0] fail_now;
  logic [TW-1:0]  ts;
  logic [3:0]     low_ch;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    seq_chk_lane #(
      .W     (W),
      .DELAY (DELAY),
      .MODE  (MODE),
      .CW    (CW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .trig     (trig[i]),
      .a        (a[i*W +: W]),
      .b        (b[i*W +: W]),
      .fail_now (fail_now[i]),
      .fail     (fail[i]),
      .pending  (pending[i]),
      .cnt      (fail_cnt[i*CW +: CW])
    );
  end

  // Walk downward so the lowest failing index wins.
  always_comb begin
    low_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (fail_now[i]) low_ch = 4'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_any        <= 1'b0;
      first_fail_vld  <= 1'b0;
      first_fail_time <= '0;
      first_fail_ch   <= '0;
    end else if (clr) begin
      fail_any        <= 1'b0;
      first_fail_vld  <= 1'b0;
      first_fail_time <= '0;
      first_fail_ch   <= '0;
    end else begin
      fail_any <= |fail_now;
      if (!first_fail_vld && (|fail_now)) begin
        first_fail_vld  <= 1'b1;
        first_fail_time <= ts;
        first_fail_ch   <= low_ch;
      end
    end
  end

endmodule

// File: tb/tb_seq_delay_checker.sv
// Directed bench: instance A (4ch, DELAY=1, GT, CW=2) and
// instance B (1ch, DELAY=3, NE, TW=4).
module tb_seq_delay_checker;
  import seq_chk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        en_a, clr_a;
  logic [3:0]  trig_a;
  logic [31:0] a_a, b_a;
  logic [3:0]  fail_a, pend_a, ch_a;
  logic        fany_a, vld_a;
  logic [7:0]  cnt_a;
  logic [15:0] time_a;

  logic        en_b, clr_b;
  logic [0:0]  trig_b, fail_b, pend_b;
  logic [7:0]  a_b, b_b, cnt_b;
  logic        fany_b, vld_b;
  logic [3:0]  time_b, ch_b;

  seq_delay_checker #(
    .NCH(4), .W(8), .DELAY(1), .MODE(CMP_GT), .CW(2), .TW(16)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .clr(clr_a),
    .trig(trig_a), .a(a_a), .b(b_a), .fail(fail_a),
    .fail_any(fany_a), .pending(pend_a), .fail_cnt(cnt_a),
    .first_fail_vld(vld_a), .first_fail_time(time_a),
    .first_fail_ch(ch_a)
  );

  seq_delay_checker #(
    .NCH(1), .W(8), .DELAY(3), .MODE(CMP_NE), .CW(8), .TW(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .clr(clr_b),
    .trig(trig_b), .a(a_b), .b(b_b), .fail(fail_b),
    .fail_any(fany_b), .pending(pend_b), .fail_cnt(cnt_b),
    .first_fail_vld(vld_b), .first_fail_time(time_b),
    .first_fail_ch(ch_b)
  );

  int ncmp = 0;
  int nerr = 0;
  int ecount = 0;
  int edge_ts = 0;
  int ff_t = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // edge_ts is the timestamp value the DUT samples at this edge.
  task automatic step();
    @(posedge clk);
    edge_ts = ecount;
    if (rst_n) ecount++;
    #1;
  endtask

  initial begin
    rst_n = 0;
    en_a = 0; clr_a = 0; trig_a = 0; a_a = 0; b_a = 0;
    en_b = 0; clr_b = 0; trig_b = 0; a_b = 0; b_b = 0;
    step(); step();
    chk("rst_fail", fail_a, 0);
    chk("rst_fany", fany_a, 0);
    chk("rst_pend", pend_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_time", time_a, 0);
    chk("rst_ch", ch_a, 0);
    chk("rst_pend_b", pend_b, 0);

    rst_n = 1;
    ecount = 0;

    // A: ramp a+=1, b+=2, trig held; saturating CW=2 counter
    en_a = 1;
    trig_a = 4'b0001;
    for (int j = 0; j < 6; j++) begin
      a_a[7:0] = 8'(j);
      b_a[7:0] = 8'(2 * j);
      step();
      chk("ramp_fail", fail_a, (j >= 1) ? 4'b0001 : 4'b0000);
      chk("ramp_cnt", cnt_a, (j >= 3) ? 8'd3 : 8'(j));
    end
    chk("ramp_vld", vld_a, 1);
    chk("ramp_time", time_a, 16'd1);
    chk("ramp_ch", ch_a, 0);
    chk("ramp_fany", fany_a, 1);
    chk("ramp_pend", pend_a, 4'b0001);

    trig_a = 0;
    step();
    chk("tail_fail", fail_a, 4'b0001);
    chk("tail_pend", pend_a, 0);
    step();
    chk("idle_fail", fail_a, 0);
    chk("idle_fany", fany_a, 0);

    // A: clr on a failing evaluation edge
    trig_a = 4'b0001;
    step();
    trig_a = 0;
    clr_a = 1;
    step();
    clr_a = 0;
    chk("clr_fail", fail_a, 0);
    chk("clr_cnt", cnt_a, 0);
    chk("clr_vld", vld_a, 0);
    chk("clr_pend", pend_a, 0);
    chk("clr_fany", fany_a, 0);

    // A: channels 2 and 0 fail together
    a_a = {8'd0, 8'd1, 8'd0, 8'd5};
    b_a = {8'd0, 8'd2, 8'd0, 8'd10};
    trig_a = 4'b0101;
    step();
    trig_a = 0;
    step();
    ff_t = edge_ts;
    chk("dual_fail", fail_a, 4'b0101);
    chk("dual_ch", ch_a, 0);
    chk("dual_vld", vld_a, 1);
    chk("dual_time", time_a, 16'(ff_t));
    chk("dual_cnt", cnt_a, 8'h11);

    // A: ch1 passes, ch3 fails; capture must hold
    a_a = {8'd2, 8'd1, 8'd3, 8'd5};
    b_a = {8'd2, 8'd2, 8'd2, 8'd10};
    trig_a = 4'b1010;
    step();
    trig_a = 0;
    step();
    chk("ch3_fail", fail_a, 4'b1000);
    chk("ch3_ch", ch_a, 0);
    chk("ch3_time", time_a, 16'(ff_t));
    chk("ch3_cnt", cnt_a, 8'h51);

    // B: DELAY=3 with en low for two edges
    en_b = 1;
    a_b = 5;
    b_b = 5;
    trig_b = 1;
    step();
    chk("stall_pend0", pend_b, 1);
    trig_b = 0;
    en_b = 0;
    step();
    chk("stall_pend1", pend_b, 1);
    chk("stall_fail1", fail_b, 0);
    step();
    chk("stall_pend2", pend_b, 1);
    en_b = 1;
    step();
    chk("stall_pend3", pend_b, 1);
    chk("stall_fail3", fail_b, 0);
    step();
    chk("stall_pend4", pend_b, 1);
    chk("stall_fail4", fail_b, 0);
    step();
    ff_t = edge_ts;
    chk("stall_eval", fail_b, 1);
    chk("stall_pend5", pend_b, 0);
    chk("stall_vld", vld_b, 1);
    chk("stall_time", time_b, 4'(ff_t));
    chk("stall_cnt", cnt_b, 1);
    step();
    chk("stall_after", fail_b, 0);

    // B: overlapping triggers, NE with a==b
    for (int s = 0; s < 6; s++) begin
      trig_b = (s < 3) ? 1'b1 : 1'b0;
      step();
      chk("ovl_fail", fail_b, (s >= 3) ? 1'b1 : 1'b0);
      chk("ovl_pend", pend_b, (s <= 4) ? 1'b1 : 1'b0);
    end
    chk("ovl_cnt", cnt_b, 4);
    chk("ovl_time", time_b, 4'(ff_t));

    // B: a!=b passes
    a_b = 6;
    trig_b = 1;
    step();
    trig_b = 0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("pass_fail", fail_b, 0);
    end
    chk("pass_cnt", cnt_b, 4);

    // B: clr beats a simultaneous trigger
    a_b = 5;
    trig_b = 1;
    clr_b = 1;
    step();
    clr_b = 0;
    trig_b = 0;
    chk("clrtrig_pend", pend_b, 0);
    chk("clrtrig_cnt", cnt_b, 0);
    chk("clrtrig_vld", vld_b, 0);
    for (int s = 0; s < 3; s++) begin
      step();
      chk("clrtrig_fail", fail_b, 0);
    end

    // A: reset with an obligation pending
    a_a = {8'd0, 8'd0, 8'd0, 8'd5};
    b_a = {8'd0, 8'd0, 8'd0, 8'd10};
    trig_a = 4'b0001;
    step();
    trig_a = 0;
    chk("prerst_pend", pend_a, 4'b0001);
    rst_n = 0;
    #1;
    chk("arst_pend", pend_a, 0);
    chk("arst_fail", fail_a, 0);
    chk("arst_fany", fany_a, 0);
    chk("arst_cnt", cnt_a, 0);
    chk("arst_vld", vld_a, 0);
    chk("arst_time", time_a, 0);
    chk("arst_ch", ch_a, 0);
    #1;
    rst_n = 1;
    ecount = 0;
    step();
    chk("post_fail0", fail_a, 0);
    step();
    chk("post_fail1", fail_a, 0);
    chk("post_pend", pend_a, 0);
    chk("post_cnt", cnt_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
